// File: rtl/title_screen_renderer_if.sv
// Raster/ROM/pixel bundle between the VGA controller, sprite ROM and colour mux.
// The renderer takes the slave side; the driver of raster inputs and ROM data takes the master side.
interface title_screen_renderer_if;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        blank;
  logic [15:0] rom_addr;
  logic [3:0]  rom_data;
  logic [7:0]  Red;
  logic [7:0]  Green;
  logic [7:0]  Blue;
  logic        pix_valid;

  modport master (
    output DrawX, DrawY, blank, rom_data,
    input  rom_addr, Red, Green, Blue, pix_valid
  );

  modport slave (
    input  DrawX, DrawY, blank, rom_data,
    output rom_addr, Red, Green, Blue, pix_valid
  );
endinterface

// File: rtl/title_screen_renderer.sv
// Title-screen sprite renderer: raster -> ROM address, ROM palette index -> RGB, fixed 3-cycle latency.
// Optional fade-in after reset is enabled by defining TITLE_FADE_EN.
module title_screen_renderer #(
  parameter int unsigned X_OFF        = 208,
  parameter int unsigned Y_OFF        = 112,
  parameter int unsigned IMG_W        = 224,
  parameter int unsigned IMG_H        = 256,
  parameter logic [3:0]  BLINK_IDX    = 4'hF,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter logic [23:0] BG_RGB       = 24'h000000
) (
  input logic                    Clk,
  input logic                    Reset,
  title_screen_renderer_if.slave bus
);

  localparam logic [9:0] X_LO = 10'(X_OFF);
  localparam logic [9:0] X_HI = 10'(X_OFF + IMG_W - 1);
  localparam logic [9:0] Y_LO = 10'(Y_OFF);
  localparam logic [9:0] Y_HI = 10'(Y_OFF + IMG_H - 1);
  localparam int unsigned FC_W = $clog2(BLINK_FRAMES);

  function automatic logic [23:0] palette(input logic [3:0] idx);
    case (idx)
      4'h0: palette = 24'h000000;
      4'h1: palette = 24'hFFFFFF;
      4'h2: palette = 24'hFF0000;
      4'h3: palette = 24'hFFD700;
      4'h4: palette = 24'h00A0FF;
      4'h5: palette = 24'h0000AA;
      4'h6: palette = 24'h00AA00;
      4'h7: palette = 24'hAA0000;
      4'h8: palette = 24'h555555;
      4'h9: palette = 24'hAAAAAA;
      4'hA: palette = 24'hFF8000;
      4'hB: palette = 24'h80FF00;
      4'hC: palette = 24'hFF00FF;
      4'hD: palette = 24'h00FFFF;
      4'hE: palette = 24'h804000;
      default: palette = 24'hFFFF00;
    endcase
  endfunction

`ifdef TITLE_FADE_EN
  // c*(lvl+1)>>3 as a sum of shifted copies of c selected by the bits of lvl+1.
  function automatic logic [7:0] fade_ch(input logic [7:0] c, input logic [2:0] lvl);
    logic [3:0]  m;
    logic [10:0] acc;
    m   = {1'b0, lvl} + 4'd1;
    acc = (m[0] ? {3'b000, c}       : 11'd0)
        + (m[1] ? {2'b00, c, 1'b0}  : 11'd0)
        + (m[2] ? {1'b0, c, 2'b00}  : 11'd0)
        + (m[3] ? {c, 3'b000}       : 11'd0);
    return 8'(acc >> 3);
  endfunction

  logic [2:0] fade_lvl;
`endif

  logic            in_win;
  logic [9:0]      x_i;
  logic [9:0]      y_i;
  logic [15:0]     y16;
  logic [15:0]     addr;
  logic            frame_start;
  logic            prev_y_nz;
  logic            win_d1, win_d2;
  logic            blank_d1, blank_d2;
  logic [FC_W-1:0] frame_cnt;
  logic            blink_on;
  logic [23:0]     pix_rgb;

  assign in_win = bus.blank
                  && (bus.DrawX >= X_LO) && (bus.DrawX <= X_HI)
                  && (bus.DrawY >= Y_LO) && (bus.DrawY <= Y_HI);
  assign x_i = bus.DrawX - X_LO;
  assign y_i = bus.DrawY - Y_LO;
  assign y16 = {6'd0, y_i};
  // y*224 = y*128 + y*64 + y*32
  assign addr = (y16 << 7) + (y16 << 6) + (y16 << 5) + {6'd0, x_i};

  // Only the first cycle of a held (0,0) counts: prev_y_nz drops as soon as DrawY is 0.
  assign frame_start = (bus.DrawX == 10'd0) && (bus.DrawY == 10'd0) && prev_y_nz;

  always_comb begin
    pix_rgb = palette(bus.rom_data);
    if (!win_d2 || (bus.rom_data == 4'h0) || ((bus.rom_data == BLINK_IDX) && !blink_on))
      pix_rgb = BG_RGB;
`ifdef TITLE_FADE_EN
    pix_rgb = {fade_ch(pix_rgb[23:16], fade_lvl),
               fade_ch(pix_rgb[15:8],  fade_lvl),
               fade_ch(pix_rgb[7:0],   fade_lvl)};
`endif
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      bus.rom_addr  <= '0;
      bus.Red       <= '0;
      bus.Green     <= '0;
      bus.Blue      <= '0;
      bus.pix_valid <= 1'b0;
      win_d1        <= 1'b0;
      win_d2        <= 1'b0;
      blank_d1      <= 1'b0;
      blank_d2      <= 1'b0;
      prev_y_nz     <= 1'b0;
      frame_cnt     <= '0;
      blink_on      <= 1'b1;
`ifdef TITLE_FADE_EN
      fade_lvl      <= '0;
`endif
    end else begin
      bus.rom_addr  <= in_win ? addr : 16'd0;
      win_d1        <= in_win;
      blank_d1      <= bus.blank;
      win_d2        <= win_d1;
      blank_d2      <= blank_d1;
      bus.Red       <= blank_d2 ? pix_rgb[23:16] : '0;
      bus.Green     <= blank_d2 ? pix_rgb[15:8]  : '0;
      bus.Blue      <= blank_d2 ? pix_rgb[7:0]   : '0;
      bus.pix_valid <= blank_d2;
      prev_y_nz     <= (bus.DrawY != 10'd0);
      if (frame_start) begin
        if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
          frame_cnt <= '0;
          blink_on  <= ~blink_on;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
`ifdef TITLE_FADE_EN
        if (fade_lvl != 3'd7)
          fade_lvl <= fade_lvl + 3'd1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_title_screen_renderer.sv
// Self-checking bench for title_screen_renderer: vector table, reset flush, blink and frame-pulse sequences.
// Expected values go into latency-aligned queues when stimulus is driven and are checked as outputs emerge.
module tb_title_screen_renderer;

`ifdef TITLE_FADE_EN
  localparam bit FADE_ON = 1'b1;
`else
  localparam bit FADE_ON = 1'b0;
`endif

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        b;
    logic [15:0] addr;
    logic [23:0] rgb;
    logic        v;
  } vec_t;

  typedef struct {
    logic [23:0] rgb;
    logic        v;
  } pix_t;

  logic Clk;
  logic Reset;
  logic force_f;
  title_screen_renderer_if bus();

  title_screen_renderer dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic logic [3:0] rom_fn(input logic [15:0] a);
    if (force_f) return 4'hF;
    if (a == 16'd19804) return 4'h3;
    return a[3:0] ^ a[7:4];
  endfunction

  // Synchronous ROM model: one cycle from rom_addr to rom_data.
  always_ff @(posedge Clk) bus.rom_data <= rom_fn(bus.rom_addr);

  logic [23:0]     pal [16];
  logic [15:0]     addr_q [$];
  pix_t            rgb_q  [$];
  int unsigned     n_cmp, n_bad;
  logic            m_prev_nz, m_blink;
  int unsigned     m_cnt, m_fade;
  vec_t            tbl [13];

  function automatic logic [23:0] fade_sc(input logic [23:0] c, input int unsigned lvl);
    logic [23:0] r;
    for (int k = 0; k < 3; k++)
      r[k*8 +: 8] = 8'((int'(c[k*8 +: 8]) * (lvl + 1)) >> 3);
    return r;
  endfunction

  function automatic int unsigned lvl_of(input int unsigned frames);
    if (!FADE_ON) return 7;
    return (frames > 7) ? 7 : frames;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic [9:0] x, input logic [9:0] y, input logic b,
                       input logic [15:0] ea, input logic [23:0] ergb, input logic ev);
    pix_t        e;
    logic [15:0] a_exp;
    logic        fs;
    a_exp = ea;
    e.rgb = ergb;
    e.v   = ev;
    Reset = rst; bus.DrawX = x; bus.DrawY = y; bus.blank = b;
    if (rst) begin
      // Reset flushes everything already in flight.
      for (int i = 0; i < rgb_q.size(); i++) begin
        rgb_q[i].rgb = '0;
        rgb_q[i].v   = 1'b0;
      end
      a_exp = '0; e.rgb = '0; e.v = 1'b0;
    end
    addr_q.push_back(a_exp);
    rgb_q.push_back(e);
    if (rst) begin
      m_prev_nz = 1'b0; m_cnt = 0; m_blink = 1'b1; m_fade = 0;
    end else begin
      fs = (x == 10'd0) && (y == 10'd0) && m_prev_nz;
      if (fs) begin
        if (m_cnt == 29) begin m_cnt = 0; m_blink = ~m_blink; end
        else m_cnt++;
        if (m_fade < 7) m_fade++;
      end
      m_prev_nz = (y != 10'd0);
    end
    @(posedge Clk);
    #1;
    chk("rom_addr", 32'(bus.rom_addr), 32'(addr_q.pop_front()));
    if (rgb_q.size() == 3) begin
      e = rgb_q.pop_front();
      chk("rgb", 32'({bus.Red, bus.Green, bus.Blue}), 32'(e.rgb));
      chk("pix_valid", 32'(bus.pix_valid), 32'(e.v));
    end
    if (rst) begin
      chk("rst_rgb", 32'({bus.Red, bus.Green, bus.Blue}), 32'd0);
      chk("rst_valid", 32'(bus.pix_valid), 32'd0);
    end
  endtask

  task automatic drive_model(input logic rst, input logic [9:0] x, input logic [9:0] y, input logic b);
    logic        win;
    int unsigned a;
    logic [3:0]  idx;
    logic [23:0] c;
    win = b && (x >= 10'd208) && (x <= 10'd431) && (y >= 10'd112) && (y <= 10'd367);
    a   = win ? (int'(y) - 112) * 224 + (int'(x) - 208) : 0;
    idx = rom_fn(16'(a));
    c   = (!win || idx == 4'h0 || (idx == 4'hF && !m_blink)) ? 24'h0 : pal[idx];
    c   = b ? fade_sc(c, FADE_ON ? m_fade : 7) : 24'h0;
    drive(rst, x, y, b, 16'(a), c, b);
  endtask

  initial begin
    pal = '{24'h000000, 24'hFFFFFF, 24'hFF0000, 24'hFFD700, 24'h00A0FF, 24'h0000AA,
            24'h00AA00, 24'hAA0000, 24'h555555, 24'hAAAAAA, 24'hFF8000, 24'h80FF00,
            24'hFF00FF, 24'h00FFFF, 24'h804000, 24'hFFFF00};
    tbl[0]  = '{10'd208, 10'd112, 1'b1, 16'd0,     24'h000000, 1'b1};
    tbl[1]  = '{10'd209, 10'd112, 1'b1, 16'd1,     24'hFFFFFF, 1'b1};
    tbl[2]  = '{10'd431, 10'd112, 1'b1, 16'd223,   24'hFF0000, 1'b1};
    tbl[3]  = '{10'd225, 10'd113, 1'b1, 16'd241,   24'h804000, 1'b1};
    tbl[4]  = '{10'd208, 10'd367, 1'b1, 16'd57120, 24'hFF0000, 1'b1};
    tbl[5]  = '{10'd431, 10'd367, 1'b1, 16'd57343, 24'h000000, 1'b1};
    tbl[6]  = '{10'd300, 10'd200, 1'b1, 16'd19804, 24'hFFD700, 1'b1};
    tbl[7]  = '{10'd207, 10'd200, 1'b1, 16'd0,     24'h000000, 1'b1};
    tbl[8]  = '{10'd432, 10'd200, 1'b1, 16'd0,     24'h000000, 1'b1};
    tbl[9]  = '{10'd300, 10'd111, 1'b1, 16'd0,     24'h000000, 1'b1};
    tbl[10] = '{10'd300, 10'd368, 1'b1, 16'd0,     24'h000000, 1'b1};
    tbl[11] = '{10'd300, 10'd200, 1'b0, 16'd0,     24'h000000, 1'b0};
    tbl[12] = '{10'd432, 10'd368, 1'b0, 16'd0,     24'h000000, 1'b0};
    n_cmp = 0; n_bad = 0;
    force_f = 1'b0;
    m_prev_nz = 1'b0; m_blink = 1'b1; m_cnt = 0; m_fade = 0;

    repeat (2) drive_model(1'b1, 10'd300, 10'd200, 1'b1);

    for (int i = 0; i < 13; i++)
      drive(1'b0, tbl[i].x, tbl[i].y, tbl[i].b, tbl[i].addr,
            fade_sc(tbl[i].rgb, lvl_of(0)), tbl[i].v);
    repeat (3) drive_model(1'b0, 10'd10, 10'd10, 1'b1);

    // Reset arriving mid-line with window pixels in flight.
    repeat (2) drive_model(1'b0, 10'd300, 10'd200, 1'b1);
    drive_model(1'b1, 10'd300, 10'd200, 1'b1);
    drive_model(1'b0, 10'd301, 10'd200, 1'b1);
    drive_model(1'b0, 10'd300, 10'd200, 1'b1);
    repeat (3) drive_model(1'b0, 10'd10, 10'd10, 1'b1);

    // Blink: 61 frames with the blinking index under the probe pixel.
    force_f = 1'b1;
    repeat (3) drive_model(1'b0, 10'd10, 10'd10, 1'b1);
    for (int f = 0; f <= 60; f++) begin
      if (f > 0) drive_model(1'b0, 10'd0, 10'd0, 1'b1);
      drive(1'b0, 10'd300, 10'd200, 1'b1, 16'd19804,
            fade_sc(((f < 30) || (f == 60)) ? pal[15] : 24'h0, lvl_of(f)), 1'b1);
      repeat (3) drive_model(1'b0, 10'd10, 10'd10, 1'b1);
    end

    // Held (0,0) must count as a single frame: blink then turns off exactly 29 frames later.
    repeat (5) drive_model(1'b0, 10'd0, 10'd0, 1'b1);
    drive(1'b0, 10'd300, 10'd200, 1'b1, 16'd19804, fade_sc(pal[15], lvl_of(61)), 1'b1);
    repeat (3) drive_model(1'b0, 10'd10, 10'd10, 1'b1);
    for (int g = 1; g <= 29; g++) begin
      drive_model(1'b0, 10'd0, 10'd0, 1'b1);
      drive(1'b0, 10'd300, 10'd200, 1'b1, 16'd19804,
            fade_sc((g <= 28) ? pal[15] : 24'h0, lvl_of(61)), 1'b1);
      repeat (3) drive_model(1'b0, 10'd10, 10'd10, 1'b1);
    end
    repeat (3) drive_model(1'b0, 10'd10, 10'd10, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
